des_sbox_engine: RTL

Parametrised DES substitution engine. It takes the 48-bit key-mixed expansion output of a Feistel round and runs it through the eight DES S-boxes, producing the 32-bit f-function result, optionally P-permuted. Throughput and area are traded by evaluating 1, 2, 4 or 8 S-boxes per cycle, time-multiplexed by an internal group counter. The block sits between the expansion/key-XOR stage and the round's L/R XOR. It has a valid/ready handshake on both sides.

---
 rtl/des_sbox_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/des_sbox_engine.sv
`default_nettype none
// ============================================================================
//  Module   : des_sbox_engine (with helper des_sbox_lut)
//  Purpose  : DES f-function substitution stage. Pushes the 48-bit key-mixed
//             expansion output through S1..S8 and returns the 32-bit result,
//             optionally P-permuted. SBOX_PER_CYCLE boxes are evaluated per
//             cycle, so one block takes N = 8/SBOX_PER_CYCLE RUN cycles.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_data[47:0]    - block input handshake
//             out_valid/out_ready/out_data[31:0] - result output handshake
//             busy                               - high in RUN or DONE
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  des_sbox_lut : one DES S-box. SBOX_ID 0..7 selects S1..S8.
//  Ports: i_idx[5:0] raw 6-bit chunk, o_val[3:0] substituted nibble.
// ----------------------------------------------------------------------------
module des_sbox_lut #(
  parameter int SBOX_ID = 0
) (
  input  logic [5:0] i_idx,
  output logic [3:0] o_val
);
  // Tables in row-major reading order: entry 0 sits in the top nibble.
  localparam logic [255:0] c_s1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] c_s2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] c_s3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] c_s4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] c_s5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] c_s6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] c_s7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] c_s8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  localparam logic [255:0] c_tab =
      (SBOX_ID == 0) ? c_s1 : (SBOX_ID == 1) ? c_s2 :
      (SBOX_ID == 2) ? c_s3 : (SBOX_ID == 3) ? c_s4 :
      (SBOX_ID == 4) ? c_s5 : (SBOX_ID == 5) ? c_s6 :
      (SBOX_ID == 6) ? c_s7 : c_s8;

  // Row is the outer bit pair {5,0}, column the middle four bits.
  logic [5:0] w_addr;
  assign w_addr = {i_idx[5], i_idx[0], i_idx[4:1]};
  assign o_val  = c_tab[255 - 4*int'(w_addr) -: 4];
endmodule

// ----------------------------------------------------------------------------
//  des_sbox_engine : top level
// ----------------------------------------------------------------------------
module des_sbox_engine #(
  parameter int SBOX_PER_CYCLE = 8,
  parameter bit OUT_PERM       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  localparam int N  = 8 / SBOX_PER_CYCLE;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  // DES P table: output bit i (1 = MSB) takes input bit c_p_tab[i-1].
  localparam int c_p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17,
                                   1, 15, 23, 26,  5, 18, 31, 10,
                                   2,  8, 24, 14, 32, 27,  3,  9,
                                  19, 13, 30,  6, 22, 11,  4, 25};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_grp;
  logic [47:0]   r_in;
  logic [31:0]   r_res;
  logic          w_accept;
  logic          w_last_grp;

  logic [5:0]    w_chunk [SBOX_PER_CYCLE];
  logic [3:0]    w_lut   [8];
  logic [3:0]    w_pos   [SBOX_PER_CYCLE];

  assign w_accept   = in_valid && in_ready;
  assign w_last_grp = (r_grp == GW'(N - 1));

  // Column j of group g handles box g*SBOX_PER_CYCLE+j; the column's chunk
  // is steered by grp so the active box always sees its own six bits.
  always_comb begin
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
      w_chunk[j] = r_in[47 - 6*(int'(r_grp)*SBOX_PER_CYCLE + j) -: 6];
    end
  end

  for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_col
    for (genvar g = 0; g < N; g++) begin : g_grp
      des_sbox_lut #(.SBOX_ID(g*SBOX_PER_CYCLE + j)) u_lut (
        .i_idx (w_chunk[j]),
        .o_val (w_lut[g*SBOX_PER_CYCLE + j])
      );
    end
    assign w_pos[j] = w_lut[int'(r_grp)*SBOX_PER_CYCLE + j];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last_grp) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = !in_ready;

  // Datapath: input latch, group counter, nibble-wise result writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp <= '0;
      r_in  <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_in  <= in_data;
        r_res <= '0;
        r_grp <= '0;
      end else if (r_state == S_RUN) begin
        for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
          r_res[31 - 4*(int'(r_grp)*SBOX_PER_CYCLE + j) -: 4] <= w_pos[j];
        end
        r_grp <= w_last_grp ? '0 : r_grp + 1'b1;
      end
    end
  end

  function automatic logic [31:0] p_perm(input logic [31:0] d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[31 - i] = d[32 - c_p_tab[i]];
    return v;
  endfunction

  // P is pure wiring off the result register, so it adds no latency.
  if (OUT_PERM) begin : g_perm
    assign out_data = p_perm(r_res);
  end else begin : g_raw
    assign out_data = r_res;
  end
endmodule
`default_nettype wire
